// File: rtl/cordic_seq_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cordic_seq_ctrl
//
// Sequencer for an iterative CORDIC datapath. One run loads the datapath once.
// For each micro-rotation it then samples the datapath sign bits (VERIFY) and
// performs one shift-add step (STEP). When the run completes it pulses done.
//
// Parameters
//   N_MAX   maximum number of micro-rotations per run
//   ITER_W  width of n_iter / iter_idx (2**ITER_W must exceed N_MAX)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request a run (only looked at in IDLE)
//   mode          0 = rotation, 1 = vectoring (latched at start)
//   n_iter        iteration count (latched at start, clamped to N_MAX)
//   abort         synchronous cancel of a run in LOAD/VERIFY/STEP
//   z_neg, y_neg  datapath sign bits, sampled in VERIFY
//   load_en       datapath loads initial X/Y/angle
//   verify_en     datapath sign bits are being sampled
//   step_en       datapath performs one micro-rotation
//   dir           registered direction for the current step (1 = add)
//   iter_idx      shift amount / atan-ROM index, valid while step_en is high
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   dbg_state     current FSM state, for debug and checker binding
//
// Handshake: start is a level request that is accepted on the rising edge
// where the block is in IDLE. It is not queued while busy. done is a
// one-cycle pulse, and the first IDLE cycle follows it.
// -----------------------------------------------------------------------------
module cordic_seq_ctrl #(
    parameter int N_MAX  = 16,
    parameter int ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              abort,
    input  logic              z_neg,
    input  logic              y_neg,
    output logic              load_en,
    output logic              verify_en,
    output logic              step_en,
    output logic              dir,
    output logic [ITER_W-1:0] iter_idx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_STEP   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [ITER_W-1:0] N_MAX_V = ITER_W'(N_MAX);
    localparam logic [ITER_W-1:0] ONE_V   = ITER_W'(1);

    state_t            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [ITER_W-1:0] n_iter_q, n_iter_d;
    logic              mode_q, mode_d;
    logic              dir_q, dir_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_iter_q <= '0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_iter_q <= n_iter_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
        end
    end

    // Next-state logic. abort is checked before every other transition in
    // LOAD/VERIFY/STEP. FINISH and IDLE ignore abort.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_iter_d = n_iter_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    mode_d   = mode;
                    n_iter_d = (n_iter > N_MAX_V) ? N_MAX_V : n_iter;
                    cnt_d    = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (n_iter_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_VERIFY;
                end
            end
            S_VERIFY: begin
                // The direction comes from the signs that the datapath presents during VERIFY.
                dir_d = mode_q ? y_neg : ~z_neg;
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == n_iter_q - ONE_V) begin
                    state_d = S_FINISH;
                end else begin
                    // The clamp keeps cnt_q below N_MAX, so this never wraps.
                    cnt_d   = cnt_q + ONE_V;
                    state_d = S_VERIFY;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode. These outputs are Moore outputs: they depend on the state only.
    always_comb begin
        load_en   = 1'b0;
        verify_en = 1'b0;
        step_en   = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        iter_idx  = '0;
        unique case (state_q)
            S_IDLE:   busy      = 1'b0;
            S_LOAD:   load_en   = 1'b1;
            S_VERIFY: verify_en = 1'b1;
            S_STEP: begin
                step_en  = 1'b1;
                iter_idx = cnt_q;
            end
            S_FINISH: done      = 1'b1;
            default:  busy      = 1'b0;
        endcase
    end

    assign dir       = dir_q;
    assign dbg_state = state_q;

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Parametrised sequencer for the iterative CORDIC datapath. It replaces the fixed-count controller and adds three things: a run-time iteration count, a rotation/vectoring mode select, and an abort. Handshakes are registered. It drives the load, step and direction strobes of the X/Y/angle datapath, and it reports busy/done to the top-level wrapper.

## Interface
Parameters:
- N_MAX, 16: maximum number of CORDIC micro-rotations.
- ITER_W, 5: width of n_iter and iter_idx. Must satisfy 2^ITER_W > N_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new run. Sampled only in IDLE.
- mode  in  1  0 = rotation (direction from angle residual), 1 = vectoring (direction from Y sign). Latched at start.
- n_iter  in  ITER_W  iterations for this run. Latched at start. Values above N_MAX are clamped to N_MAX. Value 0 means no iterations.
- abort  in  1  synchronous cancel of the current run.
- z_neg  in  1  sign bit of the datapath angle residual.
- y_neg  in  1  sign bit of the datapath Y register.
- load_en  out  1  datapath loads the initial X/Y/angle.
- verify_en  out  1  datapath sign bits are being sampled (the former verify_angleGreaterA strobe).
- step_en  out  1  datapath performs one shift-add micro-rotation.
- dir  out  1  rotation direction for the current step: 1 = add, 0 = subtract.
- iter_idx  out  ITER_W  shift amount / atan-ROM index of the current step.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, LOAD, VERIFY, STEP, FINISH. State is registered. All outputs except dir are decoded from state only (Moore). dir is a register.
- IDLE
  - If start = 1: latch mode, latch n_iter_q = min(n_iter, N_MAX), clear the counter, go to LOAD.
  - Otherwise stay.
- LOAD
  - load_en = 1.
  - If n_iter_q = 0, go to FINISH. Otherwise go to VERIFY.
- VERIFY
  - verify_en = 1.
  - Register dir: dir = ~z_neg when mode = 0, dir = y_neg when mode = 1.
  - Go to STEP.
- STEP
  - step_en = 1. iter_idx = counter. dir is stable.
  - If counter = n_iter_q-1, go to FINISH. Otherwise increment the counter and go to VERIFY.
- FINISH
  - done = 1. Go to IDLE.
- abort = 1 in LOAD, VERIFY or STEP: the next state is IDLE, no done is issued, and the counter is cleared. abort takes priority over every other transition.
- abort in FINISH is ignored; done still pulses. abort in IDLE is ignored. Simultaneous start and abort in IDLE: start wins.
- start while busy is ignored and not queued. n_iter and mode changes while busy have no effect.
- The counter is ITER_W bits wide and never wraps, because the clamp guarantees counter < N_MAX.

## Timing
- Reset, asynchronous, while rst_n = 0:
  - state = IDLE, counter = 0, iter_idx = 0, dir = 0, mode latch = 0, n_iter_q = 0.
  - load_en, verify_en, step_en, busy and done are all 0.
- Cycle numbering: start is sampled at edge 0.
  - LOAD occupies cycle 1.
  - Iteration i occupies VERIFY at cycle 2+2i and STEP at cycle 3+2i.
  - FINISH (done = 1) is cycle 2+2N, where N = n_iter_q. With N = 0, FINISH is cycle 2.
  - The earliest next start is sampled in cycle 3+2N, i.e. the first IDLE cycle.
- busy is high from cycle 1 through cycle 2+2N inclusive. It is low in the cycle where start is first sampled.
- The datapath samples z_neg/y_neg during VERIFY, which is one cycle after the previous step_en. The datapath must present updated signs by the end of VERIFY.
- Reset asserted mid-run returns the block to IDLE immediately. No done is issued.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with start = 1 -> all outputs are 0 and state is IDLE. After release with start = 1, load_en is seen 1 cycle later.
- Full run, mode = 0, n_iter = 16, z_neg toggling each iteration:
  - done at cycle 34 after start.
  - Exactly 16 step_en pulses with iter_idx 0..15.
  - Each dir equals ~z_neg as sampled in the preceding VERIFY.
- Vectoring, mode = 1, n_iter = 4, y_neg = 1,0,1,1 -> dir = 1,0,1,1 on the four steps, and done at cycle 10.
- Boundaries:
  - n_iter = 0 -> load_en in cycle 1, done in cycle 2, no step_en.
  - n_iter = 31 -> clamped to 16; done at cycle 34.
- abort during STEP with iter_idx = 5 -> busy is 0 and the block is in IDLE the next cycle, no done pulse. A new start then gives a full run with iter_idx restarting at 0.
- Hold start = 1 continuously for n_iter = 2:
  - Runs are back-to-back: done at cycle 6, next LOAD at cycle 8.
  - start pulses applied while busy cause no extra runs.
